// File: rtl/serial_conditional_complementer.sv
// Bit-serial operand conditioner: pass, ones' complement, negate or absolute value,
// one bit per clock, LSB first, behind a valid/ready handshake on each side.
module serial_conditional_complementer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ONES = 2'd1;
  localparam logic [1:0] OP_NEG  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             seen_one_reg, seen_one_next;
  logic             overflow_reg, overflow_next;
  logic             cur_bit;
  logic             res_bit;
  logic [1:0]       op_decoded;

  assign cur_bit = shift_reg[0];

  // Absolute value collapses to pass or negate at capture, so SHIFT only knows three ops.
  always_comb begin
    op_decoded = OP_PASS;
    case (mode)
      2'b00:   op_decoded = OP_PASS;
      2'b01:   op_decoded = OP_ONES;
      2'b10:   op_decoded = OP_NEG;
      default: op_decoded = din[WIDTH-1] ? OP_NEG : OP_PASS;
    endcase
  end

  always_comb begin
    res_bit = cur_bit;
    case (op_reg)
      OP_ONES: res_bit = ~cur_bit;
      OP_NEG:  res_bit = seen_one_reg ? ~cur_bit : cur_bit;
      default: res_bit = cur_bit;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    shift_next    = shift_reg;
    dout_next     = dout_reg;
    cnt_next      = cnt_reg;
    seen_one_next = seen_one_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_next    = din;
          op_next       = op_decoded;
          dout_next     = '0;
          cnt_next      = '0;
          seen_one_next = 1'b0;
          overflow_next = 1'b0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        dout_next  = {res_bit, dout_reg[WIDTH-1:1]};
        shift_next = {1'b0, shift_reg[WIDTH-1:1]};
        cnt_next   = cnt_reg + CNT_W'(1);
        if (op_reg == OP_NEG) begin
          seen_one_next = seen_one_reg | cur_bit;
        end
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
          // Only the most-negative value reaches the sign bit without an earlier 1.
          if ((op_reg == OP_NEG) && !seen_one_reg && cur_bit) begin
            overflow_next = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_PASS;
      shift_reg    <= '0;
      dout_reg     <= '0;
      cnt_reg      <= '0;
      seen_one_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      shift_reg    <= shift_next;
      dout_reg     <= dout_next;
      cnt_reg      <= cnt_next;
      seen_one_reg <= seen_one_next;
      overflow_reg <= overflow_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign dout      = dout_reg;
  assign overflow  = overflow_reg;

endmodule

// File: doc/serial_conditional_complementer.md
Name: serial_conditional_complementer

Overview:
- Parametrised, bit-serial successor to the single-bit conditional inverter.
- Accepts a WIDTH-bit word and a 2-bit mode through a valid/ready handshake.
- Processes the word LSB-first, one bit per clock. Produces pass-through, ones' complement, two's complement (negate) or absolute value.
- Sits in front of the adder/subtractor datapath as its operand-conditioning stage.

Parameters:
- WIDTH, 8, data word width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  din/mode are valid this cycle.
- in_ready  output  1  block can accept a word (high only in IDLE).
- mode  input  2  00 pass, 01 ones' complement, 10 two's complement, 11 absolute value.
- din  input  WIDTH  operand word, two's-complement signed.
- out_valid  output  1  dout/overflow hold a finished result.
- out_ready  input  1  consumer takes the result this cycle.
- dout  output  WIDTH  result word.
- overflow  output  1  result not representable (negation of most-negative value).

Behaviour:
- Reset: synchronous. Any rising edge with rst=1 forces:
  - state=IDLE, counter=0, seen_one=0;
  - dout=0, overflow=0, out_valid=0, in_ready=1 from the following cycle.
  - in_valid is ignored while rst=1.
- Reset mid-operation (SHIFT or DONE): aborts and discards the word. No out_valid pulse is produced for it.
- FSM has three states: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, so no combinational in->out paths.
- IDLE:
  - On in_valid & in_ready: capture din into a shift register and capture mode.
  - Effective op for mode 11: negate if din[WIDTH-1]=1, else pass. This is decided at capture.
  - Clear counter and seen_one, go to SHIFT.
- SHIFT: each edge processes bit b = shift_reg[0], writes result bit into dout MSB side, shifts right, increments counter.
  - pass: r = b.
  - ones' complement: r = ~b.
  - negate (mode 10, or mode 11 with negative input): r = seen_one ? ~b : b; then seen_one |= b.
  - At counter == WIDTH-1 (last bit): go to DONE.
  - If the op is negate and seen_one==0 and b==1 on the last bit (input = 1 followed by WIDTH-1 zeros): set overflow=1.
- DONE: dout and overflow are held stable. On out_ready=1: go to IDLE. out_valid drops and in_ready rises the next cycle.
- Timing: acceptance edge E0; result bits at edges E1..E_WIDTH; out_valid high in the cycle after E_WIDTH, so latency is WIDTH clocks.
  - With out_ready held high, throughput is one word per WIDTH+2 clocks.
  - No same-cycle output-accept/input-accept overlap.
- din/mode changes after acceptance have no effect. in_valid while busy is not accepted; the producer must hold it.
- Negate of zero: dout=0, overflow=0. Most-negative input in modes 10/11: dout = 1 followed by WIDTH-1 zeros, overflow=1. Modes 00/01 never set overflow.
- overflow clears on the next acceptance.

Test Plan (WIDTH=8):
- Reset, then mode=10, din=0x06 accepted at E0 -> out_valid high after E8, dout=0xFA, overflow=0; in_ready low during E1..E8.
- mode=01, din=0xA5 -> dout=0x5A; mode=00, din=0x3C -> dout=0x3C; overflow=0 for both.
- mode=11: din=0xFB -> dout=0x05; din=0x7F -> dout=0x7F; din=0x80 -> dout=0x80, overflow=1; mode=10, din=0x00 -> dout=0x00, overflow=0.
- Backpressure: result ready with out_ready low 5 cycles -> dout/out_valid held; a second in_valid word (0x11) is not accepted until one cycle after the out_ready handshake, then processes correctly.
- Reset mid-SHIFT after 3 bits -> following cycle in_ready=1, out_valid=0, dout=0; next word mode=10, din=0x01 -> 0xFF.
- Random sweep, all 256 din x 4 modes, random out_ready stalls -> every result matches the reference model; exactly one out_valid handshake per accepted word.
